costas_frame_ctl: RTL and testbench
===================================

COSTAS_FRAME_CTL -- requirements
Module: costas_frame_ctl

Interface
REQ-001 SHALL have parameter SYNC_CODE, default 8'hBC, K-symbol value marking frame sync.
REQ-002 SHALL have parameter STOP_CODE, default 8'h3C, K-symbol value marking frame stop.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8 (power of two, 4..64), output byte queue depth.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 pushSym  in  1  one decoded symbol valid this cycle.
REQ-007 symK  in  1  symbol is a control (K) character.
REQ-008 symErr  in  1  code or disparity error on this symbol.
REQ-009 symData  in  8  decoded symbol value.
REQ-010 stopIn  in  1  downstream stall; byte not consumed while high.
REQ-011 pushByte  out  1  output byte valid (queue not empty).
REQ-012 Byte  out  8  output data byte.
REQ-013 Sync  out  1  Byte is first data byte of its frame.
REQ-014 lastByte  out  1  Byte is last data byte of its frame.
REQ-015 overflow  out  1  sticky: a data byte was dropped on full queue.

Function
REQ-016 FSM states: HUNT, SYNC1, FIRST, DATA; leaves HUNT only on pushSym with symK=1, symErr=0, symData=SYNC_CODE.
REQ-017 SYNC1: second consecutive valid SYNC_CODE -> FIRST; any other symbol -> HUNT.
REQ-018 FIRST/DATA: valid non-K symbol is loaded into a one-entry hold register with first flag (set if from FIRST); state -> DATA.
REQ-019 Non-K symbol arriving while hold register full pushes held byte to queue with lastByte=0, then loads new byte.
REQ-020 Valid STOP_CODE in FIRST/DATA: held byte (if any) pushed with lastByte=1; state -> HUNT; Sync=1 and lastByte=1 together for a one-byte frame.
REQ-021 Sync then stop with no data (empty frame) SHALL produce no output.
REQ-022 symErr=1, or any K symbol other than SYNC/STOP, in FIRST/DATA: held byte discarded, state -> HUNT.
REQ-023 SYNC_CODE in FIRST/DATA: held byte discarded, state -> SYNC1.
REQ-024 Symbol-to-queue latency: byte enters queue on the edge of the following qualifying symbol (REQ-019/020); visible on outputs next cycle.
REQ-025 Queue pop when pushByte=1 and stopIn=0; Byte/Sync/lastByte held stable while stopIn=1.
REQ-026 Queue push and pop in same cycle permitted at any occupancy, including full (pop frees slot first).
REQ-027 Push to full queue without same-cycle pop: byte dropped, overflow set; queue contents unaffected.
REQ-028 Pointers wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.
REQ-029 pushSym=0 cycles SHALL not change FSM state or hold register.

Reset
REQ-030 On reset low: FSM=HUNT, hold register empty, queue empty, pushByte=0, Byte=0, Sync=0, lastByte=0, overflow=0, asynchronously.
REQ-031 Reset mid-frame discards all held/queued bytes; after release, no output until a new double sync.

Configuration
REQ-032 Macro COSTAS_FRAME_STATS_EN: when defined, adds outputs frameCount (16, frames ended by valid STOP with >=1 byte) and abortCount (16, frames ended by REQ-022/023), both saturating, reset to 0.
REQ-033 Without COSTAS_FRAME_STATS_EN: those ports and counters do not exist; all other behaviour identical.

Verification
REQ-034 Sync,Sync,00,01,02,Stop with stopIn=0 -> three pops: (00,Sync=1,last=0),(01,0,0),(02,0,1).
REQ-035 Sync,Sync,Stop -> no pushByte; then Sync,Sync,55,Stop -> one pop (55,Sync=1,last=1).
REQ-036 Frame 00..FF with stopIn random 0..10-cycle stalls -> 256 bytes in order, Sync only on 00, last only on FF, overflow=0.
REQ-037 Sync,Sync,11,22,symErr symbol,33,Stop -> one pop (11,1,0), no other bytes; abortCount=1 when enabled.
REQ-038 stopIn=1 held, frame of FIFO_DEPTH+3 bytes -> first FIFO_DEPTH bytes retained, overflow=1; after stopIn=0 exactly FIFO_DEPTH pops.
REQ-039 reset low mid-frame after 5 bytes -> outputs 0 immediately; trailing bytes and Stop after release produce nothing.

Source files
------------

// File: rtl/costas_frame_ctl.sv
// Costas frame controller: hunts for a double sync, frames decoded symbols into a byte queue.
// Optional per-frame statistics counters are enabled by defining COSTAS_FRAME_STATS_EN.
module costas_frame_ctl #(
    parameter logic [7:0]  SYNC_CODE  = 8'hBC,
    parameter logic [7:0]  STOP_CODE  = 8'h3C,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pushSym,
    input  logic        symK,
    input  logic        symErr,
    input  logic [7:0]  symData,
    input  logic        stopIn,
    output logic        pushByte,
    output logic [7:0]  Byte,
    output logic        Sync,
    output logic        lastByte,
    output logic        overflow
`ifdef COSTAS_FRAME_STATS_EN
    ,
    output logic [15:0] frameCount,
    output logic [15:0] abortCount
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StHunt, StSync1, StFirst, StData} state_e;

    state_e      state_q, state_d;
    logic        hold_valid_q, hold_valid_d;
    logic        hold_first_q, hold_first_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic        push_req, push_last;

    logic        is_sync, is_stop;
    assign is_sync = symK && !symErr && (symData == SYNC_CODE);
    assign is_stop = symK && !symErr && (symData == STOP_CODE);

    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_first_d = hold_first_q;
        hold_data_d  = hold_data_q;
        push_req     = 1'b0;
        push_last    = 1'b0;
        if (pushSym) begin
            unique case (state_q)
                StHunt: begin
                    if (is_sync) state_d = StSync1;
                end
                StSync1: begin
                    state_d = is_sync ? StFirst : StHunt;
                end
                StFirst, StData: begin
                    if (!symErr && !symK) begin
                        // The previously held byte is now known not to be the last one.
                        push_req     = hold_valid_q;
                        hold_valid_d = 1'b1;
                        hold_data_d  = symData;
                        hold_first_d = (state_q == StFirst);
                        state_d      = StData;
                    end else if (is_stop) begin
                        push_req     = hold_valid_q;
                        push_last    = 1'b1;
                        hold_valid_d = 1'b0;
                        state_d      = StHunt;
                    end else begin
                        hold_valid_d = 1'b0;
                        state_d      = is_sync ? StSync1 : StHunt;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StHunt;
            hold_valid_q <= 1'b0;
            hold_first_q <= 1'b0;
            hold_data_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_first_q <= hold_first_d;
            hold_data_q  <= hold_data_d;
        end
    end

    // Output queue: entries are {first, last, data}.
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          pop, full, push_acc;

    assign pop      = (count_q != '0) && !stopIn;
    assign full     = (count_q == FULL_COUNT);
    assign push_acc = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= {hold_first_q, push_last, hold_data_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)      rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_acc) - CW'(pop);
            if (push_req && !push_acc) overflow <= 1'b1;
        end
    end

    logic [9:0] head;
    assign head     = mem_q[rd_ptr_q];
    assign pushByte = (count_q != '0);
    assign Byte     = pushByte ? head[7:0] : 8'h00;
    assign lastByte = pushByte && head[8];
    assign Sync     = pushByte && head[9];

`ifdef COSTAS_FRAME_STATS_EN
    logic frame_end, frame_abort;
    assign frame_end   = push_req && push_last;
    assign frame_abort = pushSym && ((state_q == StFirst) || (state_q == StData)) &&
                         (symErr || (symK && !is_stop));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frameCount <= 16'h0000;
            abortCount <= 16'h0000;
        end else begin
            if (frame_end && (frameCount != 16'hFFFF))   frameCount <= frameCount + 16'd1;
            if (frame_abort && (abortCount != 16'hFFFF)) abortCount <= abortCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_costas_frame_ctl.sv
// Directed bench for costas_frame_ctl: vector table plus stream, overflow and reset sequences.
module tb_costas_frame_ctl;

    localparam int         DEPTH = 8;
    localparam logic [7:0] SY    = 8'hBC;
    localparam logic [7:0] ST    = 8'h3C;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pushSym = 1'b0, symK = 1'b0, symErr = 1'b0, stopIn = 1'b0;
    logic [7:0] symData = 8'h00;
    logic       pushByte, Sync, lastByte, overflow;
    logic [7:0] Byte;
`ifdef COSTAS_FRAME_STATS_EN
    logic [15:0] frameCount, abortCount;
`endif

    costas_frame_ctl #(
        .SYNC_CODE (SY),
        .STOP_CODE (ST),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pushSym   (pushSym),
        .symK      (symK),
        .symErr    (symErr),
        .symData   (symData),
        .stopIn    (stopIn),
        .pushByte  (pushByte),
        .Byte      (Byte),
        .Sync      (Sync),
        .lastByte  (lastByte),
        .overflow  (overflow)
`ifdef COSTAS_FRAME_STATS_EN
        ,
        .frameCount(frameCount),
        .abortCount(abortCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       push, k, err;
        logic [7:0] data;
        logic       stop;
        logic       epb;
        logic [7:0] ebyte;
        logic       esync, elast, eovf;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(input logic p, input logic k, input logic e,
                                input logic [7:0] d, input logic s, input logic epb,
                                input logic [7:0] eb, input logic es, input logic el,
                                input logic eo);
        vec_t v;
        v.push = p; v.k = k; v.err = e; v.data = d; v.stop = s;
        v.epb = epb; v.ebyte = eb; v.esync = es; v.elast = el; v.eovf = eo;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic epb, input logic [7:0] eb,
                         input logic es, input logic el, input logic eo);
        n_vec++;
        if ({pushByte, Byte, Sync, lastByte, overflow} !== {epb, eb, es, el, eo}) begin
            n_err++;
            $display("FAIL %s: got pb=%0b byte=%02h sync=%0b last=%0b ovf=%0b, want pb=%0b byte=%02h sync=%0b last=%0b ovf=%0b",
                     name, pushByte, Byte, Sync, lastByte, overflow, epb, eb, es, el, eo);
        end
    endtask

    task automatic send(input logic k, input logic e, input logic [7:0] d);
        pushSym = 1'b1; symK = k; symErr = e; symData = d;
        @(posedge clk); #1;
        pushSym = 1'b0; symK = 1'b0; symErr = 1'b0;
    endtask

    int sidx, eidx, entered, popped, stall, cyc;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Double sync, three bytes, stop
        add(1,1,0,SY,0, 0,8'h00,0,0,0);
        add(1,1,0,SY,0, 0,8'h00,0,0,0);
        add(1,0,0,8'h00,0, 0,8'h00,0,0,0);
        add(1,0,0,8'h01,0, 1,8'h00,1,0,0);
        add(1,0,0,8'h02,0, 1,8'h01,0,0,0);
        add(1,1,0,ST,0, 1,8'h02,0,1,0);
        add(0,0,0,8'h00,0, 0,8'h00,0,0,0);
        // Empty frame, then one-byte frame
        add(1,1,0,SY,0, 0,8'h00,0,0,0);
        add(1,1,0,SY,0, 0,8'h00,0,0,0);
        add(1,1,0,ST,0, 0,8'h00,0,0,0);
        add(0,0,0,8'h00,0, 0,8'h00,0,0,0);
        add(1,1,0,SY,0, 0,8'h00,0,0,0);
        add(1,1,0,SY,0, 0,8'h00,0,0,0);
        add(1,0,0,8'h55,0, 0,8'h00,0,0,0);
        add(1,1,0,ST,0, 1,8'h55,1,1,0);
        add(0,0,0,8'h00,0, 0,8'h00,0,0,0);
        // Error symbol aborts frame
        add(1,1,0,SY,0, 0,8'h00,0,0,0);
        add(1,1,0,SY,0, 0,8'h00,0,0,0);
        add(1,0,0,8'h11,0, 0,8'h00,0,0,0);
        add(1,0,0,8'h22,0, 1,8'h11,1,0,0);
        add(1,0,1,8'h33,0, 0,8'h00,0,0,0);
        add(1,0,0,8'h33,0, 0,8'h00,0,0,0);
        add(1,1,0,ST,0, 0,8'h00,0,0,0);
        // Hunt needs two consecutive valid syncs; idle cycles hold state
        add(1,1,0,SY,0, 0,8'h00,0,0,0);
        add(1,0,0,8'h77,0, 0,8'h00,0,0,0);
        add(1,1,0,SY,0, 0,8'h00,0,0,0);
        add(1,0,0,8'h88,0, 0,8'h00,0,0,0);
        add(1,0,0,8'h99,0, 0,8'h00,0,0,0);
        add(1,1,1,SY,0, 0,8'h00,0,0,0);
        add(1,1,0,SY,0, 0,8'h00,0,0,0);
        add(1,1,0,SY,0, 0,8'h00,0,0,0);
        add(0,1,0,ST,0, 0,8'h00,0,0,0);
        add(1,0,0,8'hC1,0, 0,8'h00,0,0,0);
        add(1,0,0,8'hC2,0, 1,8'hC1,1,0,0);
        add(0,0,0,8'h00,0, 0,8'h00,0,0,0);
        // Sync inside a frame discards the held byte and restarts at the second sync
        add(1,1,0,SY,0, 0,8'h00,0,0,0);
        add(1,1,0,SY,0, 0,8'h00,0,0,0);
        add(1,0,0,8'hD1,0, 0,8'h00,0,0,0);
        add(1,1,0,ST,0, 1,8'hD1,1,1,0);
        add(0,0,0,8'h00,0, 0,8'h00,0,0,0);
        // Unknown K symbol aborts
        add(1,1,0,SY,0, 0,8'h00,0,0,0);
        add(1,1,0,SY,0, 0,8'h00,0,0,0);
        add(1,0,0,8'hE1,0, 0,8'h00,0,0,0);
        add(1,1,0,8'h1C,0, 0,8'h00,0,0,0);
        add(1,1,0,ST,0, 0,8'h00,0,0,0);
        // Outputs stable under stall
        add(1,1,0,SY,0, 0,8'h00,0,0,0);
        add(1,1,0,SY,0, 0,8'h00,0,0,0);
        add(1,0,0,8'hA0,0, 0,8'h00,0,0,0);
        add(1,0,0,8'hA1,1, 1,8'hA0,1,0,0);
        add(1,0,0,8'hA2,1, 1,8'hA0,1,0,0);
        add(0,0,0,8'h00,1, 1,8'hA0,1,0,0);
        add(0,0,0,8'h00,0, 1,8'hA1,0,0,0);
        add(1,1,0,ST,1, 1,8'hA1,0,0,0);
        add(0,0,0,8'h00,0, 1,8'hA2,0,1,0);
        add(0,0,0,8'h00,0, 0,8'h00,0,0,0);

        #1;
        check("reset_state", 0, 8'h00, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        foreach (vecs[i]) begin
            pushSym = vecs[i].push; symK = vecs[i].k; symErr = vecs[i].err;
            symData = vecs[i].data; stopIn = vecs[i].stop;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), vecs[i].epb, vecs[i].ebyte, vecs[i].esync,
                  vecs[i].elast, vecs[i].eovf);
        end
        pushSym = 1'b0; stopIn = 1'b0;

`ifdef COSTAS_FRAME_STATS_EN
        n_vec++;
        if (frameCount !== 16'd4 || abortCount !== 16'd3) begin
            n_err++;
            $display("FAIL stats: got frames=%0d aborts=%0d, want frames=4 aborts=3",
                     frameCount, abortCount);
        end
`endif

        // 256-byte frame with random stalls, sender throttled to avoid overflow
        sidx = 0; eidx = 0; entered = 0; popped = 0; stall = 0; cyc = 0;
        while ((sidx < 259 || eidx < 256) && cyc < 20000) begin
            if (stall > 0) begin
                stopIn = 1'b1;
                stall--;
            end else begin
                stopIn = 1'b0;
            end
            if (pushByte && !stopIn) begin
                check("stream", 1, 8'(eidx), eidx == 0, eidx == 255, 0);
                eidx++;
                popped++;
                stall = $urandom_range(0, 10);
            end
            pushSym = 1'b0; symK = 1'b0; symErr = 1'b0;
            if (sidx < 259 && (sidx < 3 || entered - popped < DEPTH)) begin
                pushSym = 1'b1;
                if (sidx < 2) begin
                    symK = 1'b1; symData = SY;
                end else if (sidx < 258) begin
                    symK = 1'b0; symData = 8'(sidx - 2);
                end else begin
                    symK = 1'b1; symData = ST;
                end
                if (sidx >= 3) entered++;
                sidx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        pushSym = 1'b0; symK = 1'b0; stopIn = 1'b0;
        n_vec++;
        if (eidx != 256) begin
            n_err++;
            $display("FAIL stream_count: got %0d bytes, want 256", eidx);
        end
        check("stream_end", 0, 8'h00, 0, 0, 0);

        // Overflow: DEPTH+3 bytes into a stalled queue
        stopIn = 1'b1;
        send(1, 0, SY);
        send(1, 0, SY);
        for (int i = 0; i < DEPTH + 3; i++) send(0, 0, 8'(8'h40 + i));
        send(1, 0, ST);
        check("ovf_hold", 1, 8'h40, 1, 0, 1);
        stopIn = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check("ovf_drain", 1, 8'(8'h40 + i), i == 0, 0, 1);
            @(posedge clk); #1;
        end
        check("ovf_empty", 0, 8'h00, 0, 0, 1);

        // Reset in the middle of a frame
        stopIn = 1'b1;
        send(1, 0, SY);
        send(1, 0, SY);
        for (int i = 0; i < 5; i++) send(0, 0, 8'(8'hF0 + i));
        check("pre_reset", 1, 8'hF0, 1, 0, 1);
        reset = 1'b0;
        #1;
        check("async_reset", 0, 8'h00, 0, 0, 0);
`ifdef COSTAS_FRAME_STATS_EN
        n_vec++;
        if (frameCount !== 16'd0 || abortCount !== 16'd0) begin
            n_err++;
            $display("FAIL stats_reset: got frames=%0d aborts=%0d, want 0 0",
                     frameCount, abortCount);
        end
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        stopIn = 1'b0;
        for (int i = 5; i < 8; i++) begin
            send(0, 0, 8'(8'hF0 + i));
            check("post_reset", 0, 8'h00, 0, 0, 0);
        end
        send(1, 0, ST);
        check("post_reset_stop", 0, 8'h00, 0, 0, 0);
        @(posedge clk); #1;
        check("post_reset_idle", 0, 8'h00, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
